// File: rtl/multi_edge_counter_pkg.sv
// rtl/multi_edge_counter_pkg.sv - shared mode encodings for the multi-channel edge counter
// Purpose : per-channel edge-selection mode type used by the top and channel modules.
// Contents: edge_mode_t with MODE_OFF (00), MODE_RISE (01), MODE_FALL (10), MODE_BOTH (11).
package multi_edge_counter_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } edge_mode_t;

endpackage

// File: rtl/multi_edge_counter_channel.sv
// rtl/multi_edge_counter_channel.sv - one channel: synchroniser, optional glitch filter, edge detect, counter
// Purpose : synchronise one async level, detect edges selected by i_mode, count them.
// Macro   : MULTI_EDGE_COUNTER_FILTER_EN adds a FILTER_CYCLES glitch filter after the synchroniser.
// Ports   : i_clk, i_rst_n (async active-low), i_signal (async level), i_mode (edge_mode_t),
//           i_clear (sync clear), o_hit (combinational accepted edge, feeds the top's OR),
//           o_pulse (registered pulse), o_count (WIDTH-bit count), o_overflow (sticky).
module edge_count_channel
  import multi_edge_counter_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int SATURATE      = 0,
  parameter int FILTER_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_signal,
  input  logic [1:0]       i_mode,
  input  logic             i_clear,
  output logic             o_hit,
  output logic             o_pulse,
  output logic [WIDTH-1:0] o_count,
  output logic             o_overflow
);

  if (WIDTH < 2 || SYNC_STAGES < 2 || FILTER_CYCLES < 1) begin : g_bad_params
    $error("edge_count_channel: WIDTH>=2, SYNC_STAGES>=2, FILTER_CYCLES>=1 required");
  end

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync_lvl;
  logic                   w_lvl;
  logic                   r_past;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_hit;
  logic                   r_pulse;
  logic [WIDTH-1:0]       r_count;
  logic                   r_overflow;
  edge_mode_t             w_mode;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_signal};
  end

  assign w_sync_lvl = r_sync[SYNC_STAGES-1];

`ifdef MULTI_EDGE_COUNTER_FILTER_EN
  localparam int FCW = $clog2(FILTER_CYCLES + 1);

  logic           r_filt_lvl;
  logic [FCW-1:0] r_filt_cnt;

  // Filtered level follows the synchronised level only after FILTER_CYCLES
  // consecutive disagreeing samples; any agreeing sample restarts the run.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_filt_lvl <= 1'b0;
      r_filt_cnt <= '0;
    end else if (w_sync_lvl == r_filt_lvl) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == FCW'(FILTER_CYCLES - 1)) begin
      r_filt_lvl <= w_sync_lvl;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  assign w_lvl = r_filt_lvl;
`else
  assign w_lvl = w_sync_lvl;
`endif

  // Past level tracks every cycle regardless of mode, so switching mode never
  // manufactures an edge. Edge flags are registered; the mode is applied one
  // stage later, at the counting stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_past <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_past <= w_lvl;
      r_rise <= w_lvl & ~r_past;
      r_fall <= ~w_lvl & r_past;
    end
  end

  assign w_mode = edge_mode_t'(i_mode);

  always_comb begin
    w_hit = 1'b0;
    case (w_mode)
      MODE_RISE: w_hit = r_rise;
      MODE_FALL: w_hit = r_fall;
      MODE_BOTH: w_hit = r_rise | r_fall;
      default:   w_hit = 1'b0;
    endcase
  end

  // Clear coinciding with an accepted edge keeps that edge: count restarts at 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pulse    <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pulse <= w_hit;
      if (i_clear) begin
        r_count    <= w_hit ? WIDTH'(1) : '0;
        r_overflow <= 1'b0;
      end else if (w_hit) begin
        if (r_count == COUNT_MAX) begin
          r_overflow <= 1'b1;
          r_count    <= (SATURATE != 0) ? COUNT_MAX : '0;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  assign o_hit      = w_hit;
  assign o_pulse    = r_pulse;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/multi_edge_counter.sv
// rtl/multi_edge_counter.sv - multi-channel edge counter top: CHANNELS channel instances plus any-pulse OR
// Purpose : per-channel async edge counting with wrap/saturate and sticky overflow.
// Macro   : MULTI_EDGE_COUNTER_FILTER_EN enables the per-channel glitch filter (FILTER_CYCLES).
// Ports   : in_clock, in_reset_n (async active-low), in_signal[CHANNELS], in_mode[2*CHANNELS]
//           (channel c at [2c+1:2c]), in_clear[CHANNELS], out_pulse[CHANNELS],
//           out_count[CHANNELS*WIDTH] (channel c at [c*WIDTH +: WIDTH]), out_overflow[CHANNELS],
//           out_any_pulse (registered OR, aligned with out_pulse).
module multi_edge_counter
  import multi_edge_counter_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int SATURATE      = 0,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                      in_clock,
  input  logic                      in_reset_n,
  input  logic [CHANNELS-1:0]       in_signal,
  input  logic [2*CHANNELS-1:0]     in_mode,
  input  logic [CHANNELS-1:0]       in_clear,
  output logic [CHANNELS-1:0]       out_pulse,
  output logic [CHANNELS*WIDTH-1:0] out_count,
  output logic [CHANNELS-1:0]       out_overflow,
  output logic                      out_any_pulse
);

  logic [CHANNELS-1:0] w_hit;
  logic                r_any_pulse;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    edge_count_channel #(
      .WIDTH         (WIDTH),
      .SYNC_STAGES   (SYNC_STAGES),
      .SATURATE      (SATURATE),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_chan (
      .i_clk      (in_clock),
      .i_rst_n    (in_reset_n),
      .i_signal   (in_signal[g]),
      .i_mode     (in_mode[2*g +: 2]),
      .i_clear    (in_clear[g]),
      .o_hit      (w_hit[g]),
      .o_pulse    (out_pulse[g]),
      .o_count    (out_count[g*WIDTH +: WIDTH]),
      .o_overflow (out_overflow[g])
    );
  end

  // Registered from the same pre-register hits so it lines up with out_pulse.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) r_any_pulse <= 1'b0;
    else             r_any_pulse <= |w_hit;
  end

  assign out_any_pulse = r_any_pulse;

endmodule

// File: tb/tb_multi_edge_counter.sv
// tb/tb_multi_edge_counter.sv - self-checking bench for multi_edge_counter (wrap and saturate builds)
module tb_multi_edge_counter;
  import multi_edge_counter_pkg::*;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int FC = 4;
`ifdef MULTI_EDGE_COUNTER_FILTER_EN
  localparam int LAT = 4 + FC;
`else
  localparam int LAT = 4;
`endif

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [CH-1:0]   sig   = '0;
  logic [CH-1:0]   clr   = '0;
  logic [2*CH-1:0] mode  = '0;

  logic [CH-1:0]   p0, p1, o0, o1;
  logic [CH*W-1:0] c0, c1;
  logic            a0, a1;

  multi_edge_counter #(.CHANNELS(CH), .WIDTH(W), .SYNC_STAGES(2), .SATURATE(0), .FILTER_CYCLES(FC)) dut (
    .in_clock(clk), .in_reset_n(rst_n), .in_signal(sig), .in_mode(mode), .in_clear(clr),
    .out_pulse(p0), .out_count(c0), .out_overflow(o0), .out_any_pulse(a0));

  multi_edge_counter #(.CHANNELS(CH), .WIDTH(W), .SYNC_STAGES(2), .SATURATE(1), .FILTER_CYCLES(FC)) dut_sat (
    .in_clock(clk), .in_reset_n(rst_n), .in_signal(sig), .in_mode(mode), .in_clear(clr),
    .out_pulse(p1), .out_count(c1), .out_overflow(o1), .out_any_pulse(a1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [CH-1:0] mask;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_chk  = 0;
  int            n_fail = 0;
  logic [CH-1:0] prev   = '0;
  int            exp_w[CH];
  int            exp_s[CH];
  logic          exp_o[CH];

  // Scoreboard monitor: pulses must appear exactly on the predicted cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL missed_pulse: nothing seen, required mask %b at cycle %0d", sb[0].mask, sb[0].cyc);
        sb.delete(0);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        mon_e = sb.pop_front();
        n_chk++;
        if (p0 !== mon_e.mask || p1 !== mon_e.mask || a0 !== (|mon_e.mask) || a1 !== (|mon_e.mask)) begin
          n_fail++;
          $display("FAIL pulse cycle %0d: got %b/%b any %b/%b, required %b any %b",
                   cyc, p0, p1, a0, a1, mon_e.mask, |mon_e.mask);
        end
      end else if (p0 !== '0 || p1 !== '0 || a0 !== 1'b0 || a1 !== 1'b0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_pulse cycle %0d: got %b/%b any %b/%b, required none", cyc, p0, p1, a0, a1);
      end
    end
  end

  task automatic count_event(input int c);
    if (exp_w[c] == 255) begin
      exp_w[c] = 0;
      exp_o[c] = 1'b1;
    end else begin
      exp_w[c] = exp_w[c] + 1;
    end
    if (exp_s[c] == 255) exp_o[c] = 1'b1;
    else                 exp_s[c] = exp_s[c] + 1;
  endtask

  task automatic drive(input logic [CH-1:0] s);
    logic [CH-1:0] m;
    logic          r, f;
    logic [1:0]    md;
    @(posedge clk); #1;
    m = '0;
    for (int c = 0; c < CH; c++) begin
      r  = s[c] & ~prev[c];
      f  = ~s[c] & prev[c];
      md = mode[2*c +: 2];
      if ((md == MODE_RISE && r) || (md == MODE_FALL && f) || (md == MODE_BOTH && (r || f))) begin
        m[c] = 1'b1;
        count_event(c);
      end
    end
    sig  = s;
    prev = s;
    if (m != '0) sb.push_back('{cyc + LAT, m});
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      exp_w[c] = 0; exp_s[c] = 0; exp_o[c] = 1'b0;
    end
    prev = '0;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    n_chk++;
    if (p0 !== '0 || p1 !== '0 || c0 !== '0 || c1 !== '0 || o0 !== '0 || o1 !== '0 || a0 !== 1'b0 || a1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: pulse %b count %h ovf %b any %b, required all zero", p0, c0, o0, a0);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cycles(2);
  endtask

  task automatic test_rise();
    mode = 8'b00_00_00_01;
    for (int i = 0; i < 3; i++) begin
      drive(4'b0001); wait_cycles(2);
      drive(4'b0000); wait_cycles(2);
    end
    wait_cycles(LAT + 2);
    n_chk++;
    if (c0[7:0] !== 8'd3 || c1[7:0] !== 8'd3 || o0[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_count: got %0d/%0d ovf %b, required 3/3 ovf 0", c0[7:0], c1[7:0], o0[0]);
    end
  endtask

  task automatic test_modes();
    mode = 8'b00_11_10_00;
    for (int i = 0; i < 2; i++) begin
      drive(4'b1110); wait_cycles(2);
      drive(4'b0000); wait_cycles(2);
    end
    wait_cycles(LAT + 2);
    n_chk++;
    if (c0[15:8] !== 8'd2 || c0[23:16] !== 8'd4 || c0[31:24] !== 8'd0 || c0[7:0] !== 8'd3) begin
      n_fail++;
      $display("FAIL mode_counts: got ch0..3 %0d %0d %0d %0d, required 3 2 4 0",
               c0[7:0], c0[15:8], c0[23:16], c0[31:24]);
    end
    // Level already high on an off channel must not count when it is switched on.
    drive(4'b1000);
    wait_cycles(5);
    mode = 8'b01_11_10_00;
    wait_cycles(LAT + 3);
    n_chk++;
    if (c0[31:24] !== 8'd0 || c1[31:24] !== 8'd0) begin
      n_fail++;
      $display("FAIL mode_switch_no_edge: got %0d/%0d, required 0", c0[31:24], c1[31:24]);
    end
    drive(4'b0000);
    wait_cycles(LAT + 2);
  endtask

  task automatic test_toggle();
    mode = 8'b00_11_00_00;
    for (int i = 0; i < 10; i++) drive((i % 2 == 0) ? 4'b0100 : 4'b0000);
    wait_cycles(LAT + 2);
    n_chk++;
    if (c0[23:16] !== 8'd14 || c1[23:16] !== 8'd14 || c0[23:16] !== 8'(exp_w[2])) begin
      n_fail++;
      $display("FAIL toggle_count: got %0d/%0d, required 14", c0[23:16], c1[23:16]);
    end
  endtask

  task automatic test_clear();
    @(posedge clk); #1 clr = 4'b0001;
    @(posedge clk); #1 clr = 4'b0000;
    exp_w[0] = 0; exp_s[0] = 0; exp_o[0] = 1'b0;
    wait_cycles(2);
    n_chk++;
    if (c0[7:0] !== 8'd0 || c1[7:0] !== 8'd0 || c0[15:8] !== 8'd2 || o0[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL clear: got ch0 %0d/%0d ch1 %0d ovf %b, required 0/0 ch1 2 ovf 0",
               c0[7:0], c1[7:0], c0[15:8], o0[0]);
    end
  endtask

  task automatic test_overflow();
    mode = 8'b00_00_00_11;
    for (int i = 0; i < 256; i++) drive((i % 2 == 0) ? 4'b0001 : 4'b0000);
    wait_cycles(LAT + 2);
    n_chk++;
    if (c0[7:0] !== 8'd0 || o0[0] !== 1'b1 || c1[7:0] !== 8'd255 || o1[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: got wrap %0d ovf %b sat %0d ovf %b, required 0 1 255 1",
               c0[7:0], o0[0], c1[7:0], o1[0]);
    end
    for (int c = 0; c < CH; c++) begin
      n_chk++;
      if (c0[c*W +: W] !== W'(exp_w[c]) || c1[c*W +: W] !== W'(exp_s[c]) || o0[c] !== exp_o[c] || o1[c] !== exp_o[c]) begin
        n_fail++;
        $display("FAIL overflow_model ch%0d: got %0d/%0d ovf %b/%b, required %0d/%0d ovf %b",
                 c, c0[c*W +: W], c1[c*W +: W], o0[c], o1[c], exp_w[c], exp_s[c], exp_o[c]);
      end
    end
  endtask

  task automatic test_clear_with_edge();
    drive(4'b0001);
    repeat (3) @(posedge clk);
    #1 clr = 4'b0001;
    @(posedge clk); #1 clr = 4'b0000;
    exp_w[0] = 1; exp_s[0] = 1; exp_o[0] = 1'b0;
    wait_cycles(2);
    n_chk++;
    if (c0[7:0] !== 8'd1 || c1[7:0] !== 8'd1 || o0[0] !== 1'b0 || o1[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_with_edge: got %0d/%0d ovf %b/%b, required 1/1 ovf 0",
               c0[7:0], c1[7:0], o0[0], o1[0]);
    end
    drive(4'b0000);
    wait_cycles(LAT + 2);
  endtask

  task automatic test_reset_midcount();
    mode = 8'b11_11_11_11;
    drive(4'b1111);
    drive(4'b0101);
    drive(4'b1111);
    @(posedge clk); #3;
    sb.delete();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (p0 !== '0 || p1 !== '0 || c0 !== '0 || c1 !== '0 || o0 !== '0 || o1 !== '0 || a0 !== 1'b0 || a1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midcount: pulse %b count %h ovf %b any %b, required all zero", p0, c0, o0, a0);
    end
    sig = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cycles(LAT + 2);
    n_chk++;
    if (c0 !== '0 || c1 !== '0) begin
      n_fail++;
      $display("FAIL reset_release: count %h/%h, required zero", c0, c1);
    end
  endtask

  task automatic test_filter();
    mode = 8'b00_00_00_01;
    @(posedge clk); #1 sig = 4'b0001;
    repeat (3) @(posedge clk);
    #1 sig = 4'b0000;
    wait_cycles(LAT + 4);
    n_chk++;
    if (c0[7:0] !== 8'd0) begin
      n_fail++;
      $display("FAIL filter_glitch: count %0d, required 0", c0[7:0]);
    end
    drive(4'b0001);
    wait_cycles(5);
    drive(4'b0000);
    wait_cycles(LAT + 4);
    n_chk++;
    if (c0[7:0] !== 8'd1 || c1[7:0] !== 8'd1) begin
      n_fail++;
      $display("FAIL filter_pulse: count %0d/%0d, required 1", c0[7:0], c1[7:0]);
    end
  endtask

  initial begin
    test_reset();
`ifdef MULTI_EDGE_COUNTER_FILTER_EN
    test_filter();
`else
    test_rise();
    test_modes();
    test_toggle();
    test_clear();
    test_overflow();
    test_clear_with_edge();
    test_reset_midcount();
`endif
    wait_cycles(LAT + 2);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
